// File: rtl/vga_pkg.sv
// Timing defaults shared with the sync generator, plus the monitor's lock-state encoding.
package vga_pkg;

    localparam int VGA_H_TOTAL = 800;
    localparam int VGA_V_TOTAL = 525;
    localparam int VGA_H_DISP  = 640;
    localparam int VGA_V_DISP  = 480;
    localparam int CNT_W       = 10;

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } mon_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_edge_sampler.sv
// Pixel-tick qualified edge detector for HS/VS/visible; syncs are normalised so 1 = active.
module vga_edge_sampler #(
    parameter bit SYNC_POL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic p_tick,
    input  logic iHS,
    input  logic iVS,
    input  logic iVisible,
    output logic hs_rise,
    output logic vs_rise,
    output logic vis_fall,
    output logic vis
);

    logic hs_n, vs_n;
    logic hs_q, vs_q, vis_q;

    assign hs_n = SYNC_POL ? iHS : ~iHS;
    assign vs_n = SYNC_POL ? iVS : ~iVS;
    assign vis  = iVisible;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            vis_q <= 1'b0;
        end else if (p_tick) begin
            hs_q  <= hs_n;
            vs_q  <= vs_n;
            vis_q <= iVisible;
        end
    end

    assign hs_rise  = p_tick & hs_n & ~hs_q;
    assign vs_rise  = p_tick & vs_n & ~vs_q;
    assign vis_fall = p_tick & ~iVisible & vis_q;

endmodule

// File: rtl/vga_sync_monitor.sv
// Measures line/frame timing of a VGA sync stream, locks after LOCK_FRAMES good frames,
// and regenerates pixel coordinates from the syncs alone.
module vga_sync_monitor
    import vga_pkg::*;
#(
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int H_DISP      = VGA_H_DISP,
    parameter int V_DISP      = VGA_V_DISP,
    parameter bit SYNC_POL    = 1'b1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p_tick,
    input  logic             iHS,
    input  logic             iVS,
    input  logic             iVisible,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             valid,
    output logic             frame_start,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] h_meas,
    output logic [CNT_W-1:0] v_meas
);

    localparam logic [CNT_W-1:0] H_TOT_W  = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] V_TOT_W  = CNT_W'(V_TOTAL);
    localparam logic [CNT_W-1:0] H_DISP_W = CNT_W'(H_DISP);
    localparam logic [CNT_W-1:0] V_DISP_W = CNT_W'(V_DISP);
    localparam logic [3:0]       LOCK_W   = 4'(LOCK_FRAMES);

    logic hs_rise, vs_rise, vis_fall, vis;

    vga_edge_sampler #(.SYNC_POL(SYNC_POL)) u_edge (
        .clk      (clk),
        .reset    (reset),
        .p_tick   (p_tick),
        .iHS      (iHS),
        .iVS      (iVS),
        .iVisible (iVisible),
        .hs_rise  (hs_rise),
        .vs_rise  (vs_rise),
        .vis_fall (vis_fall),
        .vis      (vis)
    );

    logic [CNT_W-1:0] tick_cnt, line_cnt, run_cnt, vline_cnt;
    logic [CNT_W-1:0] h_len, v_len, vl_len;
    logic [3:0]       good_cnt, good_inc;
    logic             bad_line_seen, line_bad, frame_bad, lock_gain, lock_loss;
    mon_state_t       state;

    // A line closing on the same tick as VS still belongs to the closing frame.
    assign h_len    = sat_inc(tick_cnt);
    assign v_len    = hs_rise  ? sat_inc(line_cnt)  : line_cnt;
    assign vl_len   = vis_fall ? sat_inc(vline_cnt) : vline_cnt;
    assign good_inc = good_cnt + 4'd1;

    assign line_bad  = (hs_rise && h_len != H_TOT_W) || (vis_fall && run_cnt != H_DISP_W);
    assign frame_bad = (v_len != V_TOT_W) || (vl_len != V_DISP_W) || bad_line_seen || line_bad;
    assign lock_gain = (state == MEASURE) && vs_rise && !frame_bad && (good_inc == LOCK_W);
    assign lock_loss = (state == LOCKED) && (line_bad || (vs_rise && frame_bad));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= SEARCH;
            good_cnt      <= '0;
            bad_line_seen <= 1'b0;
            tick_cnt      <= '0;
            line_cnt      <= '0;
            run_cnt       <= '0;
            vline_cnt     <= '0;
            pixel_x       <= '0;
            pixel_y       <= '0;
            valid         <= 1'b0;
            frame_start   <= 1'b0;
            locked        <= 1'b0;
            err           <= 1'b0;
            h_meas        <= '0;
            v_meas        <= '0;
        end else begin
            frame_start <= 1'b0;
            err         <= 1'b0;
            if (p_tick) begin
                tick_cnt <= hs_rise ? '0 : sat_inc(tick_cnt);
                if (hs_rise)
                    h_meas <= h_len;
                if (vs_rise) begin
                    v_meas   <= v_len;
                    line_cnt <= '0;
                end else begin
                    line_cnt <= v_len;
                end
                run_cnt       <= vis ? sat_inc(run_cnt) : '0;
                vline_cnt     <= vs_rise ? '0 : vl_len;
                pixel_x       <= vis ? run_cnt : '0;
                pixel_y       <= vs_rise ? '0 : vl_len;
                frame_start   <= vs_rise;
                bad_line_seen <= vs_rise ? 1'b0 : (bad_line_seen | line_bad);
                valid         <= vis & (lock_gain | (locked & ~lock_loss));

                case (state)
                    SEARCH: if (vs_rise) begin
                        state    <= MEASURE;
                        good_cnt <= '0;
                    end
                    MEASURE: if (vs_rise) begin
                        if (frame_bad) begin
                            good_cnt <= '0;
                        end else if (lock_gain) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            good_cnt <= good_inc;
                        end
                    end
                    LOCKED: if (lock_loss) begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                        err    <= 1'b1;
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed-stream bench: an active-high and an active-low monitor see the same timing,
// both compared each cycle to an event-history model, plus hand-computed milestones.
module tb_vga_sync_monitor;

    localparam int HT = 20, VT = 12, HD = 12, VD = 8, LF = 2;

    logic clk = 1'b0, reset = 1'b0, p_tick = 1'b0;
    logic hs_r = 1'b0, vs_r = 1'b0, vis_r = 1'b0;
    logic [9:0] px [2], py [2], hm [2], vm [2];
    logic       vl [2], fs [2], lk [2], er [2];
    int n_chk = 0, n_fail = 0, fs_cnt = 0, err_cnt = 0, gap = 1;

    always #5 clk = ~clk;

    vga_sync_monitor #(.H_TOTAL(HT), .V_TOTAL(VT), .H_DISP(HD), .V_DISP(VD),
                       .SYNC_POL(1'b1), .LOCK_FRAMES(LF)) dut_p (
        .clk(clk), .reset(reset), .p_tick(p_tick), .iHS(hs_r), .iVS(vs_r), .iVisible(vis_r),
        .pixel_x(px[0]), .pixel_y(py[0]), .valid(vl[0]), .frame_start(fs[0]),
        .locked(lk[0]), .err(er[0]), .h_meas(hm[0]), .v_meas(vm[0]));

    vga_sync_monitor #(.H_TOTAL(HT), .V_TOTAL(VT), .H_DISP(HD), .V_DISP(VD),
                       .SYNC_POL(1'b0), .LOCK_FRAMES(LF)) dut_n (
        .clk(clk), .reset(reset), .p_tick(p_tick), .iHS(~hs_r), .iVS(~vs_r), .iVisible(vis_r),
        .pixel_x(px[1]), .pixel_y(py[1]), .valid(vl[1]), .frame_start(fs[1]),
        .locked(lk[1]), .err(er[1]), .h_meas(hm[1]), .v_meas(vm[1]));

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: outputs derived from tick timestamps and event totals since reset / last VS.
    int  t, last_hs, hs_tot, hs_at_vs, run_st, vf_tot, vf_at_vs, streak;
    bit  p_hs, p_vs, p_vis, bad_seen;
    int  e_x, e_y, e_hm, e_vm;
    bit  e_valid, e_fs, e_lock, e_err, e_vis;

    function automatic int sat(input int v);
        return (v > 1023) ? 1023 : v;
    endfunction

    task automatic model_reset();
        t = 0; last_hs = -1; hs_tot = 0; hs_at_vs = 0; run_st = 0; vf_tot = 0; vf_at_vs = 0;
        streak = -1; p_hs = 0; p_vs = 0; p_vis = 0; bad_seen = 0;
        e_x = 0; e_y = 0; e_hm = 0; e_vm = 0;
        e_valid = 0; e_fs = 0; e_lock = 0; e_err = 0; e_vis = 0;
    endtask

    task automatic model_step();
        bit hr, vr, vf, lbad, fbad;
        e_fs = 0; e_err = 0;
        if (!p_tick) return;
        hr = hs_r && !p_hs; vr = vs_r && !p_vs; vf = !vis_r && p_vis;
        lbad = 0; fbad = 0;
        if (hr) begin
            hs_tot++;
            e_hm = sat(t - last_hs);
            last_hs = t;
            if (e_hm != HT) lbad = 1;
        end
        if (vis_r && !p_vis) run_st = t;
        if (vf) begin
            vf_tot++;
            if (sat(t - run_st) != HD) lbad = 1;
        end
        e_x = vis_r ? sat(t - run_st) : 0;
        if (vr) begin
            e_vm = sat(hs_tot - hs_at_vs);
            fbad = (e_vm != VT) || (sat(vf_tot - vf_at_vs) != VD) || bad_seen || lbad;
            hs_at_vs = hs_tot; vf_at_vs = vf_tot;
            e_fs = 1;
        end
        if (streak >= LF) begin
            if (lbad || (vr && fbad)) begin e_err = 1; streak = -1; end
        end else if (vr) begin
            if (streak < 0 || fbad) streak = 0;
            else streak++;
        end
        bad_seen = vr ? 1'b0 : (bad_seen | lbad);
        e_y = sat(vf_tot - vf_at_vs);
        e_lock = (streak >= LF);
        e_vis = vis_r;
        e_valid = e_lock && vis_r;
        p_hs = hs_r; p_vs = vs_r; p_vis = vis_r;
        t++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check($sformatf("h_meas[%0d]", i), int'(hm[i]), e_hm);
                check($sformatf("v_meas[%0d]", i), int'(vm[i]), e_vm);
                check($sformatf("locked[%0d]", i), int'(lk[i]), int'(e_lock));
                check($sformatf("err[%0d]", i), int'(er[i]), int'(e_err));
                check($sformatf("frame_start[%0d]", i), int'(fs[i]), int'(e_fs));
                check($sformatf("valid[%0d]", i), int'(vl[i]), int'(e_valid));
                if (e_vis) begin
                    check($sformatf("pixel_x[%0d]", i), int'(px[i]), e_x);
                    check($sformatf("pixel_y[%0d]", i), int'(py[i]), e_y);
                end
            end
            if (fs[0]) fs_cnt++;
            if (er[0]) err_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One sampled tick followed by `gap` idle clocks carrying junk inputs.
    task automatic tick(input logic hs, input logic vs, input logic vis);
        p_tick = 1'b1; hs_r = hs; vs_r = vs; vis_r = vis;
        @(posedge clk); #1;
        for (int g = 0; g < gap; g++) begin
            p_tick = 1'b0; hs_r = 1'($urandom); vs_r = 1'($urandom); vis_r = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        p_tick = 1'b0;
        for (int k = 0; k < n; k++) begin
            hs_r = 1'($urandom); vs_r = 1'($urandom); vis_r = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0; p_tick = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic mid_reset();
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("async_rst_pixel_x", int'(px[i]), 0);
            check("async_rst_locked", int'(lk[i]), 0);
            check("async_rst_h_meas", int'(hm[i]), 0);
            check("async_rst_v_meas", int'(vm[i]), 0);
            check("async_rst_valid", int'(vl[i]), 0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic frame(input int vis_lines, input int stretch, input int rst_line,
                         input int idle_line, input bit chk);
        int vcount;
        vcount = 0;
        for (int v = 0; v < VT; v++) begin
            int len;
            len = HT + ((v == stretch) ? 1 : 0);
            for (int h = 0; h < len; h++) begin
                tick(h >= HD + 2 && h < HD + 5, v >= VD + 1 && v < VD + 3, v < vis_lines && h < HD);
                if (chk) begin
                    if (vl[0]) vcount++;
                    if (v == 0 && h == 0) begin
                        check("first_px_x", int'(px[0]), 0);
                        check("first_px_y", int'(py[0]), 0);
                    end
                    if (v == VD - 1 && h == HD - 1) begin
                        check("last_px_x", int'(px[0]), HD - 1);
                        check("last_px_y", int'(py[0]), VD - 1);
                    end
                end
                if (v == rst_line && h == 5) mid_reset();
                if (v == idle_line && h == 3) idle(1000);
            end
        end
        if (chk) check("valid_ticks_per_frame", vcount, HD * VD);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        check("reset_locked", int'(lk[0]), 0);
        check("reset_h_meas", int'(hm[0]), 0);

        // Clean stream: lock on the third VS edge after reset.
        frame(VD, -1, -1, -1, 1'b0);
        frame(VD, -1, -1, -1, 1'b0);
        check("lock_after_2_frames", int'(lk[0]), 0);
        frame(VD, -1, -1, -1, 1'b0);
        check("lock_after_3_frames", int'(lk[0]), 1);
        check("lock_after_3_frames_n", int'(lk[1]), 1);
        check("h_meas_nominal", int'(hm[0]), HT);
        check("v_meas_nominal", int'(vm[0]), VT);
        frame(VD, -1, -1, -1, 1'b1);
        check("frame_start_count", fs_cnt, 4);
        check("err_count_clean", err_cnt, 0);

        // One stretched line drops lock; relock two full frames after the next VS.
        frame(VD, 3, -1, -1, 1'b0);
        check("err_count_stretch", err_cnt, 1);
        check("unlocked_after_stretch", int'(lk[0]), 0);
        frame(VD, -1, -1, -1, 1'b0);
        check("relock_pending", int'(lk[0]), 0);
        frame(VD, -1, -1, -1, 1'b0);
        check("relocked", int'(lk[0]), 1);

        // One visible line short: never locks, never errs.
        pulse_reset();
        for (int f = 0; f < 4; f++) frame(VD - 1, -1, -1, -1, 1'b0);
        check("short_vis_locked", int'(lk[0]), 0);
        check("short_vis_err_count", err_cnt, 1);
        check("short_vis_v_meas", int'(vm[0]), VT);

        // Lock, then async reset mid-line, then relock with a long p_tick stall inside.
        pulse_reset();
        for (int f = 0; f < 3; f++) frame(VD, -1, -1, -1, 1'b0);
        check("lock_before_mid_reset", int'(lk[0]), 1);
        frame(VD, -1, 2, -1, 1'b0);
        check("search_after_mid_reset", int'(lk[0]), 0);
        frame(VD, -1, -1, 4, 1'b0);
        check("measure_after_stall", int'(lk[0]), 0);
        check("measure_after_stall_n", int'(lk[1]), 0);
        frame(VD, -1, -1, -1, 1'b0);
        check("relock_after_reset", int'(lk[0]), 1);
        check("relock_after_reset_n", int'(lk[1]), 1);

        // Saturation of both length counters.
        for (int k = 0; k < 1100; k++) tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("h_meas_saturated", int'(hm[0]), 1023);
        check("err_count_sat", err_cnt, 2);
        check("unlocked_after_sat", int'(lk[0]), 0);
        for (int k = 0; k < 1030; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            tick(1'b1, 1'b0, 1'b0);
        end
        tick(1'b0, 1'b1, 1'b0);
        check("v_meas_saturated", int'(vm[0]), 1023);
        check("v_meas_saturated_n", int'(vm[1]), 1023);
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
